uart_rx_ctrl: RTL and testbench

//  Parametrised UART receive controller: next generation of the UART_RX FSM. Integrates oversampling edge/bit

---
 rtl/uart_rx_pkg.sv | 24 ++
 rtl/uart_rx_sampler.sv | 53 +++++
 rtl/uart_rx_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_e;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_typ_e;

    localparam int MIN_PRESCALE = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-tap majority vote around the bit centre.
// vote_o is the live majority during the commit cycle; sampled_bit_o holds it afterwards.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_i,
    input  logic                  clear_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic [PRESCALE_W-1:0] edge_cnt_o,
    output logic                  sampled_bit_o,
    output logic                  sample_done_o,
    output logic                  vote_o
);

    logic [PRESCALE_W-1:0] edge_q, edge_d, half;
    logic                  tap0_q, tap1_q, bit_q;

    assign half          = prescale_i >> 1;
    assign sample_done_o = (edge_q == half + PRESCALE_W'(1));
    assign vote_o        = majority3(tap0_q, tap1_q, rx_i);
    assign edge_cnt_o    = edge_q;
    assign sampled_bit_o = bit_q;

    always_comb begin
        edge_d = edge_q + PRESCALE_W'(1);
        if (clear_i || (edge_q == prescale_i - PRESCALE_W'(1))) begin
            edge_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_q <= '0;
            bit_q  <= 1'b1;
        end else begin
            edge_q <= edge_d;
            if (sample_done_o) begin
                bit_q <= vote_o;
            end
        end
        if (edge_q == half - PRESCALE_W'(1)) begin
            tap0_q <= rx_i;
        end
        if (edge_q == half) begin
            tap1_q <= rx_i;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: FSM, deserialiser, parity/stop checks and pulse outputs.
// Define UART_RX_BREAK_DET_EN to add the break_det output and the BREAK state.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic [DATA_W-1:0]     rx_data,
    output logic                  data_valid,
    output logic                  par_error,
    output logic                  frame_error,
`ifdef UART_RX_BREAK_DET_EN
    output logic                  break_det,
`endif
    output logic                  busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d, stop2_q, stop2_d;
    par_typ_e              par_typ_q, par_typ_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]     shift_q, shift_d, rx_data_q, rx_data_d;
    logic                  par_err_q, par_err_d, stop_err_q, stop_err_d;
    logic                  stop_idx_q, stop_idx_d;
    logic                  dv_q, dv_d, pe_q, pe_d, fe_q, fe_d;
`ifdef UART_RX_BREAK_DET_EN
    logic                  brk_q, brk_d, par_bit_q, par_bit_d;
`endif

    logic [PRESCALE_W-1:0] edge_cnt;
    logic                  sampled_bit, sample_done, vote;
    logic                  clear_cnt, last_edge, stop_err_now, final_stop;

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (RX_IN),
        .clear_i      (clear_cnt),
        .prescale_i   (prescale_q),
        .edge_cnt_o   (edge_cnt),
        .sampled_bit_o(sampled_bit),
        .sample_done_o(sample_done),
        .vote_o       (vote)
    );

    // Counter is held at 0 in IDLE and on any return to IDLE so each bit state starts at 0.
    assign clear_cnt    = (state_q == IDLE) || (state_d == IDLE);
    assign last_edge    = (edge_cnt == prescale_q - PRESCALE_W'(1));
    assign stop_err_now = stop_err_q | ~vote;
    assign final_stop   = ~stop2_q | stop_idx_q;

    always_comb begin
        state_d    = state_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        stop2_d    = stop2_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        stop_idx_d = stop_idx_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        fe_d       = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        brk_d      = 1'b0;
        par_bit_d  = par_bit_q;
`endif
        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d    = START;
                    // Out-of-range prescale is clamped so the sample window stays inside the bit.
                    prescale_d = (Prescale < PRESCALE_W'(MIN_PRESCALE)) ? PRESCALE_W'(MIN_PRESCALE) : Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = par_typ_e'(PAR_TYP);
                    stop2_d    = STOP2;
                    bit_cnt_d  = '0;
                    par_err_d  = 1'b0;
                    stop_err_d = 1'b0;
                    stop_idx_d = 1'b0;
                end
            end
            START: begin
                if (last_edge) begin
                    state_d = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_done) begin
                    shift_d = {vote, shift_q[DATA_W-1:1]};
                end
                if (last_edge) begin
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (sample_done) begin
                    par_err_d = vote ^ (^shift_q) ^ (par_typ_q == PAR_ODD);
`ifdef UART_RX_BREAK_DET_EN
                    par_bit_d = vote;
`endif
                end
                if (last_edge) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sample_done) begin
                    if (final_stop) begin
`ifdef UART_RX_BREAK_DET_EN
                        if ((shift_q == '0) && !(par_en_q && par_bit_q) && stop_err_now) begin
                            state_d = BREAK;
                            brk_d   = 1'b1;
                        end else
`endif
                        begin
                            state_d = IDLE;
                            if (!par_err_q && !stop_err_now) begin
                                dv_d      = 1'b1;
                                rx_data_d = shift_q;
                            end else begin
                                pe_d = par_err_q;
                                fe_d = stop_err_now;
                            end
                        end
                    end else begin
                        stop_err_d = stop_err_now;
                    end
                end
                if (last_edge) begin
                    stop_idx_d = 1'b1;
                end
            end
`ifdef UART_RX_BREAK_DET_EN
            BREAK: begin
                if (RX_IN) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prescale_q <= PRESCALE_W'(MIN_PRESCALE);
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            stop2_q    <= 1'b0;
            bit_cnt_q  <= '0;
            rx_data_q  <= '0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            stop_idx_q <= 1'b0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_q      <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop2_q    <= stop2_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_data_q  <= rx_data_d;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
            stop_idx_q <= stop_idx_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
`ifdef UART_RX_BREAK_DET_EN
            brk_q      <= brk_d;
            par_bit_q  <= par_bit_d;
`endif
        end
        shift_q <= shift_d;
    end

    assign rx_data     = rx_data_q;
    assign data_valid  = dv_q;
    assign par_error   = pe_q;
    assign frame_error = fe_q;
    assign busy        = (state_q != IDLE);
`ifdef UART_RX_BREAK_DET_EN
    assign break_det   = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are driven bit by bit, expected pulses queued and
// compared (flags, rx_data, arrival cycle) whenever the DUT pulses.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN, PAR_TYP, STOP2;
    logic [7:0] rx_data;
    logic       data_valid, par_error, frame_error, busy;
    logic       brk_obs;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_W(8), .PRESCALE_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .rx_data    (rx_data),
        .data_valid (data_valid),
        .par_error  (par_error),
        .frame_error(frame_error),
`ifdef UART_RX_BREAK_DET_EN
        .break_det  (brk_obs),
`endif
        .busy       (busy)
    );
`ifndef UART_RX_BREAK_DET_EN
    assign brk_obs = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        bit         dv, pe, fe, brk;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input int p);
        RX_IN = b;
        idle(p);
    endtask

    // Caller must be 1 time unit after a rising edge.
    task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                              input bit s2, input bit flip_par, input bit stop_last);
        exp_t e;
        logic pbit;
        pbit   = (^d) ^ ptyp ^ flip_par;
        e.data = d;
        e.pe   = pen && flip_par;
        e.fe   = !stop_last;
        e.dv   = !e.pe && !e.fe;
        e.brk  = 1'b0;
        e.due  = cyc + (1 + 8 + int'(pen) + int'(s2)) * p + p / 2 + 3;
        sb.push_back(e);
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        STOP2    = s2;
        drive_bit(1'b0, p);
        // Scramble configuration mid-frame; the DUT must use the latched values.
        Prescale = 6'd40;
        PAR_EN   = ~pen;
        PAR_TYP  = ~ptyp;
        STOP2    = ~s2;
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        STOP2    = s2;
        if (s2) drive_bit(1'b1, p);
        drive_bit(stop_last, p);
        RX_IN = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (data_valid || par_error || frame_error || brk_obs) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {brk_obs, data_valid, par_error, frame_error}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("data_valid", data_valid, e.dv);
                    check("par_error", par_error, e.pe);
                    check("frame_error", frame_error, e.fe);
`ifdef UART_RX_BREAK_DET_EN
                    check("break_det", brk_obs, e.brk);
`endif
                    check("rx_data", rx_data, e.dv ? e.data : last_good);
                    check("latency", cyc, e.due);
                    if (e.dv) last_good = e.data;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    initial begin : stim
        rst      = 1'b1;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        STOP2    = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        check("rst_rx_data", rx_data, 8'h00);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_par_error", par_error, 1'b0);
        check("rst_frame_error", frame_error, 1'b0);
        check("rst_busy", busy, 1'b0);

        send_frame(8'hA5, 8, 0, 0, 0, 0, 1);   idle(16);
        send_frame(8'h5C, 16, 1, 1, 0, 0, 1);  idle(32);
        send_frame(8'h03, 16, 1, 0, 0, 1, 1);  idle(32);

        // One-cycle low glitch on the idle line.
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        STOP2    = 1'b0;
        RX_IN    = 1'b0;
        idle(1);
        RX_IN = 1'b1;
        check("glitch_busy_start", busy, 1'b1);
        idle(7);
        check("glitch_busy_last", busy, 1'b1);
        idle(1);
        check("glitch_busy_idle", busy, 1'b0);
        idle(16);

        send_frame(8'h81, 8, 0, 0, 1, 0, 1);   idle(16);
        send_frame(8'h5A, 8, 0, 0, 1, 0, 0);   idle(32);

        send_frame(8'h55, 8, 0, 0, 0, 0, 1);
        send_frame(8'hAA, 8, 0, 0, 0, 0, 1);   idle(16);

        // Reset in the middle of data bit 4 of 0xF0.
        Prescale = 6'd8;
        RX_IN    = 1'b0;
        idle(8);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 8);
        RX_IN = 1'b1;
        idle(4);
        rst = 1'b1;
        idle(1);
        check("abort_busy", busy, 1'b0);
        check("abort_rx_data", rx_data, 8'h00);
        check("abort_data_valid", data_valid, 1'b0);
        rst       = 1'b0;
        last_good = 8'h00;
        idle(20);
        send_frame(8'h3C, 8, 0, 0, 0, 0, 1);   idle(16);

        for (int k = 0; k < 4; k++) begin
            logic [7:0] d;
            int         p;
            bit         pen, ptyp, s2, flip;
            d    = 8'($urandom_range(0, 255));
            p    = 2 * $urandom_range(4, 12);
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            s2   = 1'($urandom_range(0, 1));
            flip = pen & 1'($urandom_range(0, 1));
            send_frame(d, p, pen, ptyp, s2, flip, 1);
            idle(2 * p);
        end

`ifdef UART_RX_BREAK_DET_EN
        begin
            exp_t e;
            Prescale = 6'd8;
            PAR_EN   = 1'b0;
            STOP2    = 1'b0;
            e.data   = 8'h00;
            e.dv     = 1'b0;
            e.pe     = 1'b0;
            e.fe     = 1'b0;
            e.brk    = 1'b1;
            e.due    = cyc + 9 * 8 + 4 + 3;
            sb.push_back(e);
            RX_IN = 1'b0;
            idle(12 * 8);
            check("break_busy_held", busy, 1'b1);
            RX_IN = 1'b1;
            idle(2);
            check("break_busy_release", busy, 1'b0);
            idle(16);
        end
`endif

        for (int i = 0; i < 3000 && sb.size() != 0; i++) idle(1);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
